// File: rtl/pipe_pal_packer.sv
// Narrow-to-wide beat packer feeding pipe_pal: W_IN-bit beats become little-endian W_DATA-bit words.
// Optional per-lane odd parity on the output word when PIPE_PACKER_PARITY_EN is defined.
module pipe_pal_packer #(
    parameter int W_DATA = 32,
    parameter int W_IN   = 8
) (
    input  logic                      i_clk,
    input  logic                      resetn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [W_IN-1:0]           s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [W_DATA-1:0]         m_data,
    output logic [W_DATA/W_IN-1:0]    m_keep,
    output logic                      m_last,
    output logic [W_DATA/W_IN-1:0]    m_par
);

    localparam int N_LANES = W_DATA / W_IN;
    localparam int W_CNT   = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(N_LANES - 1);

    logic [W_CNT-1:0]   r_cnt;
    logic [W_DATA-1:0]  r_asm_data;
    logic [N_LANES-1:0] r_asm_keep;
    logic               r_m_valid;
    logic [W_DATA-1:0]  r_m_data;
    logic [N_LANES-1:0] r_m_keep;
    logic               r_m_last;

    logic               w_accept;
    logic               w_complete;
    logic               w_m_hs;
    logic [W_DATA-1:0]  w_merge_data;
    logic [N_LANES-1:0] w_merge_keep;

    // Back-pressure only depends on the output slot, never on s_valid.
    assign s_ready    = !r_m_valid || m_ready;
    assign w_accept   = s_valid && s_ready;
    assign w_complete = w_accept && ((r_cnt == CNT_LAST) || s_last);
    assign w_m_hs     = r_m_valid && m_ready;

    // Assembly word with the current beat dropped into lane r_cnt.
    always_comb begin
        w_merge_data = r_asm_data;
        w_merge_keep = r_asm_keep;
        for (int k = 0; k < N_LANES; k++) begin
            if (r_cnt == W_CNT'(k)) begin
                w_merge_data[k*W_IN +: W_IN] = s_data;
                w_merge_keep[k]              = 1'b1;
            end else begin
                w_merge_data[k*W_IN +: W_IN] = r_asm_data[k*W_IN +: W_IN];
                w_merge_keep[k]              = r_asm_keep[k];
            end
        end
    end

    // Lane counter and assembly register; a completing beat empties the assembly.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_complete) begin
            r_cnt      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_accept) begin
            r_cnt      <= r_cnt + W_CNT'(1);
            r_asm_data <= w_merge_data;
            r_asm_keep <= w_merge_keep;
        end else begin
            r_cnt      <= r_cnt;
            r_asm_data <= r_asm_data;
            r_asm_keep <= r_asm_keep;
        end
    end

    // Output slot: a new word wins over a concurrent handshake so there is no bubble.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_complete) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_merge_data;
            r_m_keep  <= w_merge_keep;
            r_m_last  <= s_last;
        end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
            r_m_data  <= r_m_data;
            r_m_keep  <= r_m_keep;
            r_m_last  <= r_m_last;
        end else begin
            r_m_valid <= r_m_valid;
            r_m_data  <= r_m_data;
            r_m_keep  <= r_m_keep;
            r_m_last  <= r_m_last;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_last  = r_m_last;

`ifdef PIPE_PACKER_PARITY_EN
    logic [N_LANES-1:0] r_m_par;

    function automatic logic [N_LANES-1:0] lane_odd_parity(
        input logic [W_DATA-1:0]  data,
        input logic [N_LANES-1:0] keep
    );
        logic [N_LANES-1:0] p;
        p = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (keep[k]) begin
                p[k] = ~^data[k*W_IN +: W_IN];
            end else begin
                p[k] = 1'b0;
            end
        end
        return p;
    endfunction

    // Parity loads on the same edge as the word it protects.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            r_m_par <= '0;
        end else if (w_complete) begin
            r_m_par <= lane_odd_parity(w_merge_data, w_merge_keep);
        end else begin
            r_m_par <= r_m_par;
        end
    end

    assign m_par = r_m_par;
`else
    assign m_par = '0;
`endif

endmodule
